ready_scoreboard: RTL and testbench
===================================

READY_SCOREBOARD -- requirements
Module: ready_scoreboard

Interface
REQ-001 SHALL have parameter NUM_WB, default 2, number of writeback ports.
REQ-002 SHALL have parameter TAG_W, default 5, physical register tag width.
REQ-003 SHALL have port clk  input  1  sole clock, all state updated on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port alloc_valid  input  1  rename allocated a new destination tag this cycle.
REQ-006 SHALL have port alloc_tag  input  TAG_W  tag being allocated.
REQ-007 SHALL have port wb_valid  input  NUM_WB  per-port writeback strobe.
REQ-008 SHALL have port wb_tag  input  NUM_WB*TAG_W  packed writeback tags, port p at [p*TAG_W +: TAG_W].
REQ-009 SHALL have port flush  input  1  speculative squash.
REQ-010 SHALL have port done_flags  output  30  bit k high means tag k+2 holds a completed value; consumed directly by issue entries.
REQ-011 SHALL have port pending_count  output  5  number of tags currently not done (0..30).
REQ-012 SHALL have port err  output  2  sticky errors: [0] writeback to done tag, [1] allocation of pending tag.

Function
REQ-013 Tags 0 and 1 SHALL be reserved and permanently ready, with no done_flags bit; alloc or wb to them is ignored and raises no error.
REQ-014 Per cycle, the next state SHALL be computed as: start from the current flags, set bits for all valid wb ports, then clear the bit for alloc (alloc wins over a same-cycle wb of the same tag).
REQ-015 Registered done_flags SHALL reflect a writeback or allocation one cycle after the strobe.
REQ-016 Multiple wb ports naming the same tag in one cycle SHALL be legal and equivalent to one writeback.
REQ-017 flush SHALL set all 30 flags to 1 next cycle and SHALL override alloc and wb in the same cycle.
REQ-018 pending_count SHALL be registered and SHALL equal the popcount of zero bits in the registered flags, with no other latency.
REQ-019 err[0] SHALL set when a valid wb targets a tag whose flag is already 1, unless a same-cycle alloc cleared it.
REQ-020 err[1] SHALL set when alloc targets a tag whose flag is 0, unless a same-cycle wb sets it; err bits clear only on reset.
REQ-021 Errors SHALL NOT be raised during a flush cycle.

Reset
REQ-022 While rst is high, done_flags SHALL be all ones, pending_count 0, and err 0, asynchronously.
REQ-023 Reset asserted mid-operation SHALL discard all pending state; the first edge after deassertion SHALL process inputs normally.

Configuration
REQ-024 With SCOREBOARD_BYPASS_EN defined, done_flags SHALL additionally OR in the decoded tags of same-cycle valid wb ports combinationally (zero-cycle wakeup), masked by a same-cycle alloc of that tag, and forced all-ones during flush.
REQ-025 Without SCOREBOARD_BYPASS_EN, done_flags SHALL be purely registered; pending_count and err SHALL be identical in both builds.

Structure
REQ-026 TAG_W, the reserved-tag count (2), and the done-flag width (30) SHALL live in the shared defines package alongside RENAMED_OP_SZ.
REQ-027 Tag-to-one-hot decode SHALL be a shared function in the package; a sub-module popcount30 SHALL compute pending_count.

Verification
REQ-028 Reset, then alloc tag 7 -> next cycle done_flags[5]=0, pending_count=1; wb port0 tag 7 -> next cycle done_flags[5]=1, pending_count=0.
REQ-029 Same cycle: alloc tag 9, wb port1 tag 9 (previously pending) -> flag[7]=0, err=0.
REQ-030 wb port0 tag 12 and port1 tag 12 while pending -> flag[10]=1, err=0; repeat wb tag 12 -> err[0]=1 and stays 1.
REQ-031 Allocate tags 2..31 over 30 cycles -> pending_count=30; flush with alloc tag 3 -> done_flags=all ones, pending_count=0, err=0.
REQ-032 With SCOREBOARD_BYPASS_EN: tag 20 pending, wb tag 20 -> done_flags[18]=1 in the same cycle; without it -> 1 only next cycle.
REQ-033 Assert rst asynchronously between edges with 5 tags pending -> outputs go to reset values immediately; alloc/wb of tags 0, 1 -> no state or err change.

Source files
------------

// File: rtl/ready_scoreboard_pkg.sv
// Shared defines for the ready scoreboard: tag geometry, reserved-tag count,
// done-flag width and the tag-to-one-hot decode used by rename/issue logic.
package ready_scoreboard_pkg;

  // Physical register tag width.
  localparam int TAG_W = 5;

  // Tags 0 and 1 are hard-wired ready and never tracked.
  localparam int NUM_RSVD = 2;

  // One done flag per tracked tag (tags 2..31).
  localparam int DONE_W = 30;

  // Renamed operand field: a tag plus its ready bit.
  localparam int RENAMED_OP_SZ = TAG_W + 1;

  // Width of the pending counter (holds 0..DONE_W).
  localparam int CNT_W = 5;

  // Decode a tag into the done-flag bit space. Reserved and out-of-range
  // tags decode to all zeros, so they can never touch state or errors.
  function automatic logic [DONE_W-1:0] tag_onehot(input logic [31:0] tag);
    logic [DONE_W-1:0] oh;
    oh = '0;
    for (int k = 0; k < DONE_W; k++) begin
      oh[k] = (tag == 32'(k + NUM_RSVD));
    end
    return oh;
  endfunction

endpackage

// File: rtl/ready_scoreboard_popcount30.sv
// Population count of a 30-bit vector; used for the pending-tag counter.
module popcount30
  import ready_scoreboard_pkg::*;
(
  input  logic [DONE_W-1:0] bits,
  output logic [CNT_W-1:0]  count
);

  // Plain adder chain; synthesis rebalances it into a tree.
  always_comb begin
    count = '0;
    for (int i = 0; i < DONE_W; i++) begin
      count = count + CNT_W'(bits[i]);
    end
  end

endmodule

// File: rtl/ready_scoreboard.sv
// Ready scoreboard: one done flag per physical tag 2..31, cleared on
// allocation, set on writeback, forced all-ones on flush. Also tracks the
// number of pending tags and sticky protocol errors.
//
// Optional feature: define SCOREBOARD_BYPASS_EN to OR same-cycle writebacks
// into done_flags combinationally (zero-cycle wakeup). pending_count and err
// are the same in both builds.
//
// Interface semantics: alloc_valid, wb_valid[p] and flush are single-cycle
// strobes sampled on the rising edge of clk. There is no back-pressure; the
// scoreboard accepts every strobe in the cycle it is presented.
module ready_scoreboard
  import ready_scoreboard_pkg::*;
#(
  parameter int NUM_WB = 2,
  parameter int TAG_W  = ready_scoreboard_pkg::TAG_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alloc_valid,
  input  logic [TAG_W-1:0]        alloc_tag,
  input  logic [NUM_WB-1:0]       wb_valid,
  input  logic [NUM_WB*TAG_W-1:0] wb_tag,
  input  logic                    flush,
  output logic [DONE_W-1:0]       done_flags,
  output logic [CNT_W-1:0]        pending_count,
  output logic [1:0]              err
);

  logic [DONE_W-1:0] flags_q;
  logic [DONE_W-1:0] flags_next;
  logic [DONE_W-1:0] alloc_oh;
  logic [DONE_W-1:0] wb_oh;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_next;
  logic [1:0]        err_q;
  logic [1:0]        err_next;
  logic              wb_done_hit;
  logic              alloc_pend_hit;

  // Decode this cycle's allocation and writebacks into flag space.
  // Several ports naming the same tag simply OR together.
  always_comb begin
    alloc_oh = alloc_valid ? tag_onehot(32'(alloc_tag)) : '0;
    wb_oh    = '0;
    for (int p = 0; p < NUM_WB; p++) begin
      if (wb_valid[p]) begin
        wb_oh = wb_oh | tag_onehot(32'(wb_tag[p*TAG_W +: TAG_W]));
      end
    end
  end

  // Next flag state: set by writebacks, then cleared by allocation so a
  // same-cycle alloc of a written-back tag leaves it pending. Flush wins.
  always_comb begin
    if (flush) begin
      flags_next = '1;
    end else begin
      flags_next = (flags_q | wb_oh) & ~alloc_oh;
    end
  end

  // Error detection. A writeback to an already-done tag is only legal when
  // the same cycle re-allocates it; an allocation of a pending tag is only
  // legal when the same cycle completes it. Nothing is flagged on flush.
  always_comb begin
    wb_done_hit    = |(wb_oh & flags_q & ~alloc_oh);
    alloc_pend_hit = |(alloc_oh & ~flags_q & ~wb_oh);
    err_next       = err_q;
    if (!flush) begin
      err_next[0] = err_q[0] | wb_done_hit;
      err_next[1] = err_q[1] | alloc_pend_hit;
    end
  end

  // Count pending tags of the next state so the registered count lines up
  // exactly with the registered flags.
  popcount30 u_popcount (
    .bits  (~flags_next),
    .count (count_next)
  );

  // State registers; reset makes every tag ready and clears sticky errors.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= '1;
      count_q <= '0;
      err_q   <= '0;
    end else begin
      flags_q <= flags_next;
      count_q <= count_next;
      err_q   <= err_next;
    end
  end

`ifdef SCOREBOARD_BYPASS_EN
  // Zero-cycle wakeup: expose same-cycle writebacks immediately, except for
  // a tag being re-allocated in that cycle. Flush reads as all ready.
  always_comb begin
    if (flush) begin
      done_flags = '1;
    end else begin
      done_flags = flags_q | (wb_oh & ~alloc_oh);
    end
  end
`else
  // Purely registered view of the flags.
  always_comb begin
    done_flags = flags_q;
  end
`endif

  assign pending_count = count_q;
  assign err           = err_q;

endmodule

// File: tb/tb_ready_scoreboard.sv
// Self-checking bench for ready_scoreboard: directed scenarios with literal
// expectations plus a randomized phase checked against a per-tag model
// through an expected-value queue.
module tb_ready_scoreboard;

  localparam int W = 37;  // {err[1:0], pending_count[4:0], done_flags[29:0]}

  logic        clk;
  logic        rst;
  logic        alloc_valid;
  logic [4:0]  alloc_tag;
  logic [1:0]  wb_valid;
  logic [9:0]  wb_tag;
  logic        flush;
  logic [29:0] done_flags;
  logic [4:0]  pending_count;
  logic [1:0]  err;

  int tests_run;
  int tests_failed;

  logic [W-1:0] exp_q[$];
  logic [29:0]  model_flags;
  logic [1:0]   model_err;

  ready_scoreboard #(.NUM_WB(2), .TAG_W(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .alloc_valid   (alloc_valid),
    .alloc_tag     (alloc_tag),
    .wb_valid      (wb_valid),
    .wb_tag        (wb_tag),
    .flush         (flush),
    .done_flags    (done_flags),
    .pending_count (pending_count),
    .err           (err)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_idle();
    alloc_valid = 1'b0;
    alloc_tag   = '0;
    wb_valid    = '0;
    wb_tag      = '0;
    flush       = 1'b0;
  endtask

  // Reference model: walks each tracked tag independently.
  task automatic model_next(input logic av, input logic [4:0] at, input logic [1:0] wv,
                            input logic [9:0] wt, input logic fl);
    logic [29:0] nf;
    logic [1:0]  ne;
    logic        wb_hit;
    logic        al_hit;
    int          cnt;
    nf = model_flags;
    ne = model_err;
    if (fl) begin
      nf = '1;
    end else begin
      for (int k = 0; k < 30; k++) begin
        wb_hit = (wv[0] && (int'(wt[4:0]) == k + 2)) || (wv[1] && (int'(wt[9:5]) == k + 2));
        al_hit = av && (int'(at) == k + 2);
        if (wb_hit && model_flags[k] && !al_hit) ne[0] = 1'b1;
        if (al_hit && !model_flags[k] && !wb_hit) ne[1] = 1'b1;
        if (wb_hit) nf[k] = 1'b1;
        if (al_hit) nf[k] = 1'b0;
      end
    end
    model_flags = nf;
    model_err   = ne;
    cnt = 0;
    for (int k = 0; k < 30; k++) if (!nf[k]) cnt++;
    exp_q.push_back({ne, 5'(cnt), nf});
  endtask

  // One clocked transaction: drive at negedge, predict, then check the
  // registered result with inputs idle (so the bypass path cannot mask it).
  task automatic cycle(input logic av, input logic [4:0] at, input logic [1:0] wv,
                       input logic [9:0] wt, input logic fl);
    logic [W-1:0] e;
    @(negedge clk);
    alloc_valid = av;
    alloc_tag   = at;
    wb_valid    = wv;
    wb_tag      = wt;
    flush       = fl;
    model_next(av, at, wv, wt, fl);
    @(posedge clk);
    #1 set_idle();
    #1;
    e = exp_q.pop_front();
    check("state", {err, pending_count, done_flags}, e);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    set_idle();
    model_flags = '1;
    model_err   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_flags", done_flags, 30'h3fff_ffff);
    check("rst_cnt_err", {err, pending_count}, 7'd0);
    rst = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    set_idle();
    model_flags  = '1;
    model_err    = '0;

    // Alloc then writeback of tag 7.
    apply_reset();
    cycle(1'b1, 5'd7, 2'b00, 10'd0, 1'b0);
    check("a7_flag", done_flags[5], 1'b0);
    check("a7_cnt", pending_count, 5'd1);
    cycle(1'b0, 5'd0, 2'b01, {5'd0, 5'd7}, 1'b0);
    check("w7_flag", done_flags[5], 1'b1);
    check("w7_cnt", pending_count, 5'd0);

    // Same-cycle alloc and wb of pending tag 9: alloc wins, no error.
    cycle(1'b1, 5'd9, 2'b00, 10'd0, 1'b0);
    cycle(1'b1, 5'd9, 2'b10, {5'd9, 5'd0}, 1'b0);
    check("aw9_flag", done_flags[7], 1'b0);
    check("aw9_err", err, 2'b00);

    // Dual-port wb of tag 12 is one writeback; a repeat is an error.
    cycle(1'b1, 5'd12, 2'b00, 10'd0, 1'b0);
    cycle(1'b0, 5'd0, 2'b11, {5'd12, 5'd12}, 1'b0);
    check("w12_flag", done_flags[10], 1'b1);
    check("w12_err", err, 2'b00);
    cycle(1'b0, 5'd0, 2'b01, {5'd0, 5'd12}, 1'b0);
    check("w12_dup_err", err[0], 1'b1);
    cycle(1'b0, 5'd0, 2'b00, 10'd0, 1'b0);
    check("w12_sticky", err[0], 1'b1);

    // Fill all 30 tags, then flush with a colliding alloc.
    apply_reset();
    for (int t = 2; t < 32; t++) cycle(1'b1, 5'(t), 2'b00, 10'd0, 1'b0);
    check("full_cnt", pending_count, 5'd30);
    check("full_flags", done_flags, 30'd0);
    cycle(1'b1, 5'd3, 2'b00, 10'd0, 1'b1);
    check("flush_flags", done_flags, 30'h3fff_ffff);
    check("flush_cnt_err", {err, pending_count}, 7'd0);

    // Zero-cycle wakeup behaviour of tag 20.
    apply_reset();
    cycle(1'b1, 5'd20, 2'b00, 10'd0, 1'b0);
    @(negedge clk);
    wb_valid = 2'b01;
    wb_tag   = {5'd0, 5'd20};
    #1;
`ifdef SCOREBOARD_BYPASS_EN
    check("byp_same_cycle", done_flags[18], 1'b1);
`else
    check("byp_same_cycle", done_flags[18], 1'b0);
`endif
    set_idle();
    cycle(1'b0, 5'd0, 2'b01, {5'd0, 5'd20}, 1'b0);
    check("byp_next_cycle", done_flags[18], 1'b1);

    // Asynchronous reset mid-operation with 5 tags pending.
    apply_reset();
    for (int t = 2; t < 7; t++) cycle(1'b1, 5'(t), 2'b00, 10'd0, 1'b0);
    check("pre_arst_cnt", pending_count, 5'd5);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_flags", done_flags, 30'h3fff_ffff);
    check("arst_cnt_err", {err, pending_count}, 7'd0);
    model_flags = '1;
    model_err   = '0;
    @(negedge clk);
    rst = 1'b0;

    // Reserved tags never change state or raise errors.
    cycle(1'b1, 5'd0, 2'b00, 10'd0, 1'b0);
    cycle(1'b0, 5'd0, 2'b10, {5'd1, 5'd0}, 1'b0);
    cycle(1'b1, 5'd1, 2'b11, {5'd0, 5'd1}, 1'b0);
    check("rsvd_flags", done_flags, 30'h3fff_ffff);
    check("rsvd_cnt_err", {err, pending_count}, 7'd0);

    // Randomized traffic checked against the model.
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            2'($urandom_range(0, 3)), 10'($urandom_range(0, 1023)),
            ($urandom_range(0, 19) == 0));
    end

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
